// File: rtl/adc_scan_master.sv
// ---------------------------------------------------------------------------
// adc_scan_master
//
// Scans an SPI-style multiplexed ADC (LTC2308-like protocol) round-robin over
// channels 0..NUM_CH-1.  Each frame pulses CONVST, waits for the conversion
// to finish, then clocks 12 SCK periods.  During those periods the result of
// the previous conversion is shifted in on SDO while the configuration word
// selecting the *next* channel is shifted out on SDI.  The ADC therefore runs
// one channel behind the config, so the first frame of every run is discarded.
//
// Ports
//   clk           system clock, all logic on the rising edge
//   reset         synchronous, active-high reset
//   enable        level-sensitive scan enable
//   adc_convst    conversion-start strobe to the ADC (2 clk cycles wide)
//   adc_sck       serial clock to the ADC, idles low
//   adc_sdi       configuration bits to the ADC, MSB first
//   adc_sdo       result bits from the ADC, MSB first
//   a0..a7        latest 12-bit result per channel (unused channels stay 0)
//   sample_valid  one-cycle pulse when a result register is written
//   sample_ch     channel index written with sample_valid (0 otherwise)
//   scan_done     one-cycle pulse when channel NUM_CH-1 is written
// ---------------------------------------------------------------------------
module adc_scan_master #(
    parameter int SCK_DIV     = 2,
    parameter int CONV_CYCLES = 80,
    parameter int NUM_CH      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic [11:0] a0,
    output logic [11:0] a1,
    output logic [11:0] a2,
    output logic [11:0] a3,
    output logic [11:0] a4,
    output logic [11:0] a5,
    output logic [11:0] a6,
    output logic [11:0] a7,
    output logic        sample_valid,
    output logic [2:0]  sample_ch,
    output logic        scan_done
);

    typedef enum logic [2:0] {
        IDLE,
        CONVST,
        WAIT,
        SHIFT,
        STORE
    } state_t;

    localparam logic [9:0] LAST_WAIT = 10'(CONV_CYCLES - 1);
    localparam logic [7:0] LAST_DIV  = 8'(SCK_DIV - 1);
    localparam logic [2:0] LAST_CH   = 3'(NUM_CH - 1);

    state_t      state_q;
    logic [9:0]  cnt_q;
    logic [7:0]  div_q;
    logic [4:0]  half_q;
    logic [11:0] shift_q;
    logic [2:0]  nxt_q;
    logic [2:0]  cur_q;
    logic        discard_q;
    logic        convst_q;
    logic        sck_q;
    logic        sdi_q;
    logic        valid_q;
    logic        done_q;
    logic [2:0]  ch_q;
    logic [11:0] a_q [8];

    logic        sampleNow_d;
    logic        halfEnd_d;
    logic [4:0]  nextHalf_d;
    logic [2:0]  nxtInc_d;
    logic [11:0] shift_d;

    // Config bit for SCK period 'period' (0-based) when selecting channel
    // 'ch': {1, ch[0], ch[2], ch[1], 1, 0} followed by six zeros.
    function automatic logic cfgBit(input logic [3:0] period, input logic [2:0] ch);
        logic bitVal;
        case (period)
            4'd0:    bitVal = 1'b1;
            4'd1:    bitVal = ch[0];
            4'd2:    bitVal = ch[2];
            4'd3:    bitVal = ch[1];
            4'd4:    bitVal = 1'b1;
            default: bitVal = 1'b0;
        endcase
        return bitVal;
    endfunction

    // SDO is captured in the first clk cycle of each SCK high phase.  With
    // SCK_DIV=1 that cycle is also the last cycle of SHIFT, so the store path
    // uses shift_d to include the bit being captured on the same edge.
    assign sampleNow_d = (state_q == SHIFT) && half_q[0] && (div_q == 8'd0);
    assign shift_d     = sampleNow_d ? {shift_q[10:0], adc_sdo} : shift_q;
    assign halfEnd_d   = (div_q == LAST_DIV);
    assign nextHalf_d  = half_q + 5'd1;
    assign nxtInc_d    = (nxt_q == LAST_CH) ? 3'd0 : nxt_q + 3'd1;

    // Frame sequencer.  Every output is a register that is loaded on the
    // edge that enters the state it belongs to, so the outputs line up
    // exactly with the state they describe.  half_q counts the 24 SCK half
    // periods (even = low, odd = high); div_q counts clk cycles inside a
    // half period.  SDI is only updated on entry to a low half, which keeps
    // it stable across the whole high half.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            half_q    <= '0;
            shift_q   <= '0;
            nxt_q     <= '0;
            cur_q     <= '0;
            discard_q <= 1'b1;
            convst_q  <= 1'b0;
            sck_q     <= 1'b0;
            sdi_q     <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ch_q      <= '0;
            for (int k = 0; k < 8; k++) begin
                a_q[k] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ch_q    <= '0;
            if (sampleNow_d) begin
                shift_q <= shift_d;
            end
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q  <= CONVST;
                        convst_q <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                CONVST: begin
                    if (cnt_q == 10'd1) begin
                        state_q  <= WAIT;
                        convst_q <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                WAIT: begin
                    if (cnt_q == LAST_WAIT) begin
                        state_q <= SHIFT;
                        div_q   <= '0;
                        half_q  <= '0;
                        sck_q   <= 1'b0;
                        sdi_q   <= cfgBit(4'd0, nxt_q);
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                SHIFT: begin
                    if (halfEnd_d) begin
                        div_q <= '0;
                        if (half_q == 5'd23) begin
                            state_q <= STORE;
                            sck_q   <= 1'b0;
                            sdi_q   <= 1'b0;
                            if (!discard_q) begin
                                a_q[cur_q] <= shift_d;
                                valid_q    <= 1'b1;
                                ch_q       <= cur_q;
                                done_q     <= (cur_q == LAST_CH);
                            end
                        end else begin
                            half_q <= nextHalf_d;
                            sck_q  <= nextHalf_d[0];
                            if (!nextHalf_d[0]) begin
                                sdi_q <= cfgBit(nextHalf_d[4:1], nxt_q);
                            end
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                STORE: begin
                    // Continuing a run advances the channel pipeline; stopping
                    // rewinds it so the next run starts at channel 0 and
                    // throws away its first (stale) result.
                    if (enable) begin
                        state_q   <= CONVST;
                        convst_q  <= 1'b1;
                        cnt_q     <= '0;
                        cur_q     <= nxt_q;
                        nxt_q     <= nxtInc_d;
                        discard_q <= 1'b0;
                    end else begin
                        state_q   <= IDLE;
                        nxt_q     <= '0;
                        discard_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign adc_convst   = convst_q;
    assign adc_sck      = sck_q;
    assign adc_sdi      = sdi_q;
    assign sample_valid = valid_q;
    assign sample_ch    = ch_q;
    assign scan_done    = done_q;
    assign a0           = a_q[0];
    assign a1           = a_q[1];
    assign a2           = a_q[2];
    assign a3           = a_q[3];
    assign a4           = a_q[4];
    assign a5           = a_q[5];
    assign a6           = a_q[6];
    assign a7           = a_q[7];

endmodule

// File: tb/tb_adc_scan_master.sv
// ---------------------------------------------------------------------------
// tb_adc_scan_master
//
// Two instances run side by side from the same clock, reset and enable:
//   inst0: defaults (SCK_DIV=2, CONV_CYCLES=80, NUM_CH=6)
//   inst1: SCK_DIV=1, CONV_CYCLES=1, NUM_CH=1
// Each instance talks to its own ADC model, which decodes the config word
// from SDI and answers with a value that depends on the converted channel.
// A frame-position model predicts every output on every cycle.
// ---------------------------------------------------------------------------
module tb_adc_scan_master;

    localparam int NI = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;

    logic        convstO [NI];
    logic        sckO    [NI];
    logic        sdiO    [NI];
    logic        sdoI    [NI];
    logic        validO  [NI];
    logic        doneO   [NI];
    logic [2:0]  chO     [NI];
    logic [11:0] aO      [NI][8];

    int errors = 0;
    int checks = 0;
    int adcMode = 0;
    bit modelReady = 1'b0;

    // Behavioural frame model state
    int          inF   [NI];
    int          pos   [NI];
    int          nxtM  [NI];
    int          curM  [NI];
    int          discM [NI];
    logic [11:0] aM    [NI][8];

    // ADC model state
    logic [11:0] adcWord [NI];
    logic [11:0] cfgBits [NI];
    int          bitIdx  [NI];
    int          cfgCnt  [NI];
    int          cfgCh   [NI];
    logic        prevCv  [NI];
    logic        prevSck [NI];

    adc_scan_master #(.SCK_DIV(2), .CONV_CYCLES(80), .NUM_CH(6)) dut0 (
        .clk(clk), .reset(reset), .enable(enable),
        .adc_convst(convstO[0]), .adc_sck(sckO[0]), .adc_sdi(sdiO[0]), .adc_sdo(sdoI[0]),
        .a0(aO[0][0]), .a1(aO[0][1]), .a2(aO[0][2]), .a3(aO[0][3]),
        .a4(aO[0][4]), .a5(aO[0][5]), .a6(aO[0][6]), .a7(aO[0][7]),
        .sample_valid(validO[0]), .sample_ch(chO[0]), .scan_done(doneO[0])
    );

    adc_scan_master #(.SCK_DIV(1), .CONV_CYCLES(1), .NUM_CH(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable),
        .adc_convst(convstO[1]), .adc_sck(sckO[1]), .adc_sdi(sdiO[1]), .adc_sdo(sdoI[1]),
        .a0(aO[1][0]), .a1(aO[1][1]), .a2(aO[1][2]), .a3(aO[1][3]),
        .a4(aO[1][4]), .a5(aO[1][5]), .a6(aO[1][6]), .a7(aO[1][7]),
        .sample_valid(validO[1]), .sample_ch(chO[1]), .scan_done(doneO[1])
    );

    always #5 clk = ~clk;

    function automatic int pDiv(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int pConv(input int i);
        return (i == 0) ? 80 : 1;
    endfunction

    function automatic int pCh(input int i);
        return (i == 0) ? 6 : 1;
    endfunction

    function automatic int frameLen(input int i);
        return 2 + pConv(i) + 24 * pDiv(i) + 1;
    endfunction

    function automatic logic [11:0] adcValue(input int mode, input int ch);
        return (mode == 0) ? 12'hA5C : 12'(ch * 'h111);
    endfunction

    function automatic logic cfgExp(input int ch, input int period);
        logic [2:0]  c;
        logic [11:0] w;
        c = 3'(ch);
        w = {1'b1, c[0], c[2], c[1], 1'b1, 1'b0, 6'b0};
        return w[11 - period];
    endfunction

    task automatic checkOutput(input string name, input int inst,
                               input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s inst%0d at %0t: actual=%0h required=%0h", name, inst, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input int cycles);
        reset  = r;
        enable = e;
        repeat (cycles) @(negedge clk);
    endtask

    // Waits for a rising edge of convst (sel=0) or sample_valid (sel=1).
    task automatic waitRise(input int inst, input int sel, input int budget,
                            output int cyc, output int nv);
        logic prev;
        logic cur;
        bit   found;
        cyc   = 0;
        nv    = 0;
        found = 1'b0;
        prev  = (sel == 0) ? convstO[inst] : validO[inst];
        while (!found && cyc < budget) begin
            @(negedge clk);
            cyc++;
            nv += int'(validO[inst]);
            cur = (sel == 0) ? convstO[inst] : validO[inst];
            if (cur && !prev) found = 1'b1;
            prev = cur;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitRise inst%0d sel%0d: no edge within %0d cycles", inst, sel, budget);
            cyc = -1;
        end
    endtask

    // Frame model: tracks only whether a frame is running, the cycle position
    // inside it, and the channel pipeline.  Result registers are written when
    // the position reaches the last cycle of a non-discarded frame.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                inF[i] = 0; pos[i] = 0; nxtM[i] = 0; curM[i] = 0; discM[i] = 1;
                for (int k = 0; k < 8; k++) aM[i][k] = '0;
            end else if (inF[i] == 0) begin
                if (enable) begin
                    inF[i] = 1; pos[i] = 0;
                end
            end else if (pos[i] == frameLen(i) - 1) begin
                if (enable) begin
                    curM[i] = nxtM[i]; nxtM[i] = (nxtM[i] + 1) % pCh(i); discM[i] = 0; pos[i] = 0;
                end else begin
                    inF[i] = 0; nxtM[i] = 0; discM[i] = 1;
                end
            end else begin
                pos[i]++;
                if (pos[i] == frameLen(i) - 1 && discM[i] == 0)
                    aM[i][curM[i]] = adcValue(adcMode, curM[i]);
            end
        end
        modelReady = 1'b1;
    end

    // ADC models plus the per-cycle comparison against the frame model.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic [7:0]  expCtl;
            logic [7:0]  actCtl;
            logic [95:0] expA;
            logic [95:0] actA;
            int s;
            int half;
            logic eCv, eSck, eSdi, eVal, eDone;
            logic [2:0] eCh;

            if (reset) begin
                sdoI[i] = 1'b0; prevCv[i] = 1'b0; prevSck[i] = 1'b0;
                cfgCnt[i] = 0; cfgCh[i] = 0; bitIdx[i] = 0; adcWord[i] = '0; cfgBits[i] = '0;
            end else begin
                if (convstO[i] && !prevCv[i]) begin
                    adcWord[i] = adcValue(adcMode, cfgCh[i]);
                    bitIdx[i]  = 0;
                    sdoI[i]    = adcWord[i][11];
                    cfgCnt[i]  = 0;
                end
                if (sckO[i] && !prevSck[i]) begin
                    cfgBits[i] = {cfgBits[i][10:0], sdiO[i]};
                    cfgCnt[i]++;
                    if (cfgCnt[i] == 12) begin
                        cfgCh[i] = int'({cfgBits[i][9], cfgBits[i][8], cfgBits[i][10]});
                        if (i == 0 && nxtM[0] == 3)
                            checkOutput("sdiWordCh3", i, 96'(cfgBits[i]), 96'(12'hD80));
                    end
                end
                if (!sckO[i] && prevSck[i]) begin
                    bitIdx[i]++;
                    sdoI[i] = (bitIdx[i] < 12) ? adcWord[i][11 - bitIdx[i]] : 1'b0;
                end
                prevCv[i]  = convstO[i];
                prevSck[i] = sckO[i];
            end

            if (modelReady) begin
                eCv = 1'b0; eSck = 1'b0; eSdi = 1'b0; eVal = 1'b0; eDone = 1'b0; eCh = '0;
                if (inF[i] != 0) begin
                    eCv = (pos[i] < 2);
                    s = pos[i] - 2 - pConv(i);
                    if (s >= 0 && s < 24 * pDiv(i)) begin
                        half = s / pDiv(i);
                        eSck = (half % 2) == 1;
                        eSdi = cfgExp(nxtM[i], half / 2);
                    end
                    if (pos[i] == frameLen(i) - 1 && discM[i] == 0) begin
                        eVal  = 1'b1;
                        eCh   = 3'(curM[i]);
                        eDone = (curM[i] == pCh(i) - 1);
                    end
                end
                expCtl = {eCv, eSck, eSdi, eVal, eCh, eDone};
                actCtl = {convstO[i], sckO[i], sdiO[i], validO[i], chO[i], doneO[i]};
                checkOutput("ctl{cv,sck,sdi,val,ch,done}", i, 96'(actCtl), 96'(expCtl));
                for (int k = 0; k < 8; k++) begin
                    expA[k*12 +: 12] = aM[i][k];
                    actA[k*12 +: 12] = aO[i][k];
                end
                checkOutput("aRegs", i, actA, expA);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int nv;
        int nVal;
        int nDone;
        int doneCh;
        int nValB;
        int nDoneB;
        int cvH;
        int sckR;
        int sckH;
        logic prevS;

        // Reset state
        applyStimulus(1'b1, 1'b0, 3);
        for (int i = 0; i < NI; i++) begin
            checkOutput("resetCtl", i, 96'({convstO[i], sckO[i], sdiO[i], validO[i], chO[i], doneO[i]}), 96'(0));
            checkOutput("resetA0", i, 96'(aO[i][0]), 96'(0));
        end

        // Constant ADC value: first frame discarded, second delivers a0
        adcMode = 0;
        applyStimulus(1'b0, 1'b1, 0);
        waitRise(0, 0, 300, cyc, nv);
        waitRise(0, 0, 300, cyc, nv);
        checkOutput("frameLenA", 0, 96'(cyc), 96'(131));
        checkOutput("firstFrameNoValid", 0, 96'(nv), 96'(0));
        waitRise(0, 1, 300, cyc, nv);
        checkOutput("validCycleInFrame", 0, 96'(cyc + 1), 96'(131));
        checkOutput("a0Value", 0, 96'(aO[0][0]), 96'(12'hA5C));
        checkOutput("sampleCh0", 0, 96'(chO[0]), 96'(0));

        // Fast instance: convst width, SCK pulse count/width, frame length
        waitRise(1, 0, 100, cyc, nv);
        cvH = int'(convstO[1]); sckR = 0; sckH = int'(sckO[1]); prevS = sckO[1];
        for (int k = 1; k < 28; k++) begin
            @(negedge clk);
            cvH  += int'(convstO[1]);
            sckH += int'(sckO[1]);
            if (sckO[1] && !prevS) sckR++;
            prevS = sckO[1];
        end
        waitRise(1, 0, 100, cyc, nv);
        checkOutput("convstWidthB", 1, 96'(cvH), 96'(2));
        checkOutput("sckPulsesB", 1, 96'(sckR), 96'(12));
        checkOutput("sckHighCyclesB", 1, 96'(sckH), 96'(12));
        checkOutput("frameLenB", 1, 96'(27 + cyc), 96'(28));

        // Per-channel values over 7 frames
        applyStimulus(1'b1, 1'b0, 3);
        adcMode = 1;
        applyStimulus(1'b0, 1'b1, 0);
        nVal = 0; nDone = 0; doneCh = -1; nValB = 0; nDoneB = 0; cyc = 0;
        while (nVal < 6 && cyc < 1200) begin
            @(negedge clk);
            cyc++;
            if (validO[0]) nVal++;
            if (doneO[0]) begin nDone++; doneCh = int'(chO[0]); end
            if (validO[1]) nValB++;
            if (doneO[1]) nDoneB++;
        end
        checkOutput("sixSamples", 0, 96'(nVal), 96'(6));
        checkOutput("scanDoneCount", 0, 96'(nDone), 96'(1));
        checkOutput("scanDoneCh", 0, 96'(doneCh), 96'(5));
        for (int k = 0; k < 6; k++)
            checkOutput("chanValue", 0, 96'(aO[0][k]), 96'(k * 'h111));
        checkOutput("unusedA6", 0, 96'(aO[0][6]), 96'(0));
        checkOutput("unusedA7", 0, 96'(aO[0][7]), 96'(0));
        checkOutput("singleChDoneEveryValid", 1, 96'(nDoneB), 96'(nValB));

        // Enable dropped during WAIT, then re-enabled
        waitRise(0, 0, 300, cyc, nv);
        repeat (10) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 200);
        checkOutput("idleOutputs", 0, 96'({convstO[0], sckO[0], sdiO[0]}), 96'(0));
        adcMode = 0;
        applyStimulus(1'b0, 1'b1, 400);
        checkOutput("restartA0", 0, 96'(aO[0][0]), 96'(12'hA5C));
        checkOutput("restartA1", 0, 96'(aO[0][1]), 96'(12'hA5C));
        checkOutput("restartA2kept", 0, 96'(aO[0][2]), 96'(12'h222));

        // Reset during SHIFT after the 5th SCK period
        waitRise(0, 0, 300, cyc, nv);
        repeat (103) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1);
        for (int i = 0; i < NI; i++) begin
            checkOutput("midResetCtl", i, 96'({convstO[i], sckO[i], sdiO[i], validO[i], chO[i], doneO[i]}), 96'(0));
            for (int k = 0; k < 8; k++)
                checkOutput("midResetA", i, 96'(aO[i][k]), 96'(0));
        end
        applyStimulus(1'b0, 1'b1, 300);

        // Randomized enable/reset traffic
        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), 0);
                adcMode = int'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            applyStimulus(1'b0, ($urandom_range(0, 3) != 0), int'($urandom_range(1, 400)));
        end
        applyStimulus(1'b0, 1'b0, 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
